// File: rtl/fft_pkg.sv
// Shared FFT constants and framing types for fft_wrapper and its downstream peak detector.
package fft_pkg;
   localparam int unsigned DEF_DATA_W  = 25;
   localparam int unsigned DEF_FFT_LEN = 1024;
   localparam int unsigned DEF_BIN_W   = 10;
   localparam int unsigned DEF_MAG_W   = 2 * DEF_DATA_W;

   typedef enum logic {
      IDLE  = 1'b0,
      FRAME = 1'b1
   } state_t;

   // Frame tags carried alongside each beat through the magnitude pipeline
   typedef struct packed {
      logic sop;
      logic eop;
   } tag_t;
endpackage

// File: rtl/mag_sq.sv
// Two-stage squared-magnitude pipeline: S1 squares re/im, S2 sums them.
// Valid, frame tags and bin index ride along so they stay aligned with the data.
module mag_sq
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned BIN_W  = DEF_BIN_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_valid,
   input  tag_t                     i_tag,
   input  logic [BIN_W-1:0]         i_bin,
   input  logic signed [DATA_W-1:0] i_real,
   input  logic signed [DATA_W-1:0] i_imag,
   output logic                     o_valid,
   output tag_t                     o_tag,
   output logic [BIN_W-1:0]         o_bin,
   output logic [2*DATA_W-1:0]      o_mag
);
   localparam int unsigned MAG_W = 2 * DATA_W;

   logic signed [MAG_W-1:0] w_re_ext, w_im_ext;
   logic                    r_s1_valid, r_s2_valid;
   tag_t                    r_s1_tag, r_s2_tag;
   logic [BIN_W-1:0]        r_s1_bin, r_s2_bin;
   logic signed [MAG_W-1:0] r_s1_re_sq, r_s1_im_sq;
   logic [MAG_W-1:0]        r_s2_mag;

   assign w_re_ext = {{DATA_W{i_real[DATA_W-1]}}, i_real};
   assign w_im_ext = {{DATA_W{i_imag[DATA_W-1]}}, i_imag};

   // Squares are non-negative, so the unsigned sum holds the 2^49 worst case
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_tag   <= '0;
         r_s1_bin   <= '0;
         r_s1_re_sq <= '0;
         r_s1_im_sq <= '0;
         r_s2_valid <= 1'b0;
         r_s2_tag   <= '0;
         r_s2_bin   <= '0;
         r_s2_mag   <= '0;
      end else begin
         r_s1_valid <= i_valid;
         r_s1_tag   <= i_tag;
         r_s1_bin   <= i_bin;
         r_s1_re_sq <= w_re_ext * w_re_ext;
         r_s1_im_sq <= w_im_ext * w_im_ext;
         r_s2_valid <= r_s1_valid;
         r_s2_tag   <= r_s1_tag;
         r_s2_bin   <= r_s1_bin;
         r_s2_mag   <= $unsigned(r_s1_re_sq) + $unsigned(r_s1_im_sq);
      end
   end

   assign o_valid = r_s2_valid;
   assign o_tag   = r_s2_tag;
   assign o_bin   = r_s2_bin;
   assign o_mag   = r_s2_mag;
endmodule

// File: rtl/fft_peak_detector.sv
// Tracks the strongest bin of each FFT output frame and reports it once per good frame;
// malformed frames raise frame_err instead.
module fft_peak_detector
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned FFT_LEN = DEF_FFT_LEN,
   parameter int unsigned BIN_W   = DEF_BIN_W,
   parameter int unsigned MIN_BIN = 1,
   parameter int unsigned MAX_BIN = 511
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     in_sop,
   input  logic                     in_eop,
   input  logic signed [DATA_W-1:0] in_real,
   input  logic signed [DATA_W-1:0] in_imag,
   output logic                     peak_valid,
   output logic [BIN_W-1:0]         peak_bin,
   output logic [2*DATA_W-1:0]      peak_mag,
   output logic                     frame_err
);
   localparam int unsigned      MAG_W    = 2 * DATA_W;
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
   localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(MIN_BIN);
   localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(MAX_BIN);

   logic                     r_in_valid, r_in_sop, r_in_eop;
   logic signed [DATA_W-1:0] r_in_real, r_in_imag;
   state_t                   r_state, w_state_nxt;
   logic [BIN_W-1:0]         r_bin, w_bin;
   logic                     w_active, w_good, w_err;
   tag_t                     w_tag;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_in_valid <= 1'b0;
         r_in_sop   <= 1'b0;
         r_in_eop   <= 1'b0;
         r_in_real  <= '0;
         r_in_imag  <= '0;
      end else begin
         r_in_valid <= in_valid;
         r_in_sop   <= in_valid & in_sop;
         r_in_eop   <= in_valid & in_eop;
         r_in_real  <= in_real;
         r_in_imag  <= in_imag;
      end
   end

   // Framing decisions for the beat sitting in the input register
   always_comb begin
      w_state_nxt = r_state;
      w_bin       = r_bin + BIN_W'(1);
      w_active    = 1'b0;
      w_good      = 1'b0;
      w_err       = 1'b0;
      if (r_in_valid) begin
         if (r_in_sop) begin
            w_bin    = '0;
            w_active = 1'b1;
            w_err    = (r_state == FRAME);
         end else if (r_state == FRAME) begin
            w_active = 1'b1;
         end
         if (w_active) begin
            if (r_in_eop) begin
               w_state_nxt = IDLE;
               if (w_bin == LAST_BIN) w_good = 1'b1;
               else                   w_err  = 1'b1;
            end else if (w_bin == LAST_BIN) begin
               w_state_nxt = IDLE;
               w_err       = 1'b1;
            end else begin
               w_state_nxt = FRAME;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_bin     <= '0;
         frame_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         frame_err <= w_err;
         if (w_active) r_bin <= w_bin;
      end
   end

   // Only a well-formed end of frame is tagged eop downstream
   assign w_tag = '{sop: r_in_sop, eop: w_good};

   logic             w_s2_valid;
   tag_t             w_s2_tag;
   logic [BIN_W-1:0] w_s2_bin;
   logic [MAG_W-1:0] w_s2_mag;

   mag_sq #(
      .DATA_W (DATA_W),
      .BIN_W  (BIN_W)
   ) u_mag_sq (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_active),
      .i_tag   (w_tag),
      .i_bin   (w_bin),
      .i_real  (r_in_real),
      .i_imag  (r_in_imag),
      .o_valid (w_s2_valid),
      .o_tag   (w_s2_tag),
      .o_bin   (w_s2_bin),
      .o_mag   (w_s2_mag)
   );

   logic             r_have;
   logic [MAG_W-1:0] r_max, w_best_mag;
   logic [BIN_W-1:0] r_max_bin, w_best_bin;
   logic             w_in_range, w_have, w_take;

   // sop restarts the search; strict compare keeps the lowest bin on ties
   always_comb begin
      w_in_range = (w_s2_bin >= LO_BIN) && (w_s2_bin <= HI_BIN);
      w_have     = r_have & ~w_s2_tag.sop;
      w_take     = w_s2_valid & w_in_range & (~w_have | (w_s2_mag > r_max));
      w_best_mag = w_take ? w_s2_mag : r_max;
      w_best_bin = w_take ? w_s2_bin : r_max_bin;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_have     <= 1'b0;
         r_max      <= '0;
         r_max_bin  <= '0;
         peak_valid <= 1'b0;
         peak_bin   <= '0;
         peak_mag   <= '0;
      end else begin
         peak_valid <= 1'b0;
         if (w_s2_valid) begin
            r_have    <= w_have | w_take;
            r_max     <= w_best_mag;
            r_max_bin <= w_best_bin;
            if (w_s2_tag.eop) begin
               peak_valid <= 1'b1;
               peak_bin   <= w_best_bin;
               peak_mag   <= w_best_mag;
            end
         end
      end
   end
endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed frames into fft_peak_detector; a scoreboard queue holds expected peaks/errors
// and a negedge monitor checks value and arrival cycle of every output pulse.
module tb_fft_peak_detector;
   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid, in_sop, in_eop;
   logic signed [24:0] in_real, in_imag;
   logic               peak_valid, frame_err;
   logic [9:0]         peak_bin;
   logic [49:0]        peak_mag;

   fft_peak_detector dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_sop     (in_sop),
      .in_eop     (in_eop),
      .in_real    (in_real),
      .in_imag    (in_imag),
      .peak_valid (peak_valid),
      .peak_bin   (peak_bin),
      .peak_mag   (peak_mag),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          bin;
      logic [49:0] mag;
      int          at;
   } pk_t;

   pk_t  peak_q[$];
   int   err_q[$];
   int   total = 0;
   int   bad = 0;
   int   last_cyc = 0;
   bit   gaps = 0;
   logic signed [24:0] fre[1024];
   logic signed [24:0] fim[1024];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (peak_valid) begin
         if (peak_q.size() == 0) chk("unexpected_peak", 64'd1, 64'd0);
         else begin
            pk_t e;
            e = peak_q.pop_front();
            chk("peak_bin", 64'(peak_bin), 64'(e.bin));
            chk("peak_mag", 64'(peak_mag), 64'(e.mag));
            chk("peak_cycle", 64'(cyc), 64'(e.at));
         end
      end
      if (frame_err) begin
         if (err_q.size() == 0) chk("unexpected_err", 64'd1, 64'd0);
         else chk("err_cycle", 64'(cyc), 64'(err_q.pop_front()));
      end
   end

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sop   = 1'($urandom_range(0, 1));
      in_eop   = 1'($urandom_range(0, 1));
      in_real  = 25'($urandom);
      in_imag  = 25'($urandom);
   endtask

   task automatic beat(input bit sop, input bit eop, input int idx);
      if (gaps) while ($urandom_range(0, 3) == 0) idle();
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      in_real  = fre[idx];
      in_imag  = fim[idx];
      last_cyc = cyc;
   endtask

   task automatic send(input int n, input bit with_eop);
      for (int i = 0; i < n; i++) beat(i == 0, with_eop && (i == n - 1), i % 1024);
   endtask

   task automatic clr();
      for (int i = 0; i < 1024; i++) begin
         fre[i] = '0;
         fim[i] = '0;
      end
   endtask

   // Beat sampled one edge after it is driven; outputs lag that edge by 3 (peak) or 1 (err)
   task automatic expect_peak(input int bin, input logic [49:0] mag);
      peak_q.push_back('{bin, mag, last_cyc + 4});
   endtask

   task automatic expect_err();
      err_q.push_back(last_cyc + 2);
   endtask

   initial begin
      repeat (90000) @(posedge clk);
      $display("FAIL timeout actual=%0d required<90000 cycles", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [49:0] full;
      full = 50'(64'd1 << 49);
      reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      in_real = '0; in_imag = '0;
      clr();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_peak_valid", 64'(peak_valid), 64'd0);
      chk("rst_peak_bin", 64'(peak_bin), 64'd0);
      chk("rst_peak_mag", 64'(peak_mag), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      reset = 1'b0;

      // Single tone, then back-to-back tie/DC frame, full-scale and MAX_BIN edge frames
      fre[37] = 25'sd3; fim[37] = -25'sd4;
      send(1024, 1'b1); expect_peak(37, 50'd25);
      clr(); fre[0] = 25'sd1000; fre[20] = 25'sd100; fre[30] = 25'sd100;
      send(1024, 1'b1); expect_peak(20, 50'd10000);
      clr(); fre[5] = -25'sd16777216; fim[5] = -25'sd16777216;
      send(1024, 1'b1); expect_peak(5, full);
      clr(); fre[511] = 25'sd1; fim[511] = 25'sd1; fre[512] = 25'sd50;
      send(1024, 1'b1); expect_peak(511, 50'd2);

      // Malformed frames: early eop, re-sop mid frame, overrun without eop
      clr(); fre[100] = 25'sd9;
      send(601, 1'b1); expect_err();
      send(300, 1'b0);
      beat(1'b1, 1'b0, 0); expect_err();
      for (int i = 1; i <= 10; i++) beat(1'b0, i == 10, i);
      expect_err();
      send(1024, 1'b0); expect_err();
      beat(1'b0, 1'b0, 0);
      repeat (8) idle();
      @(negedge clk);
      chk("held_bin", 64'(peak_bin), 64'd511);
      chk("held_mag", 64'(peak_mag), 64'd2);

      // Gapped back-to-back frames, reset partway through the second
      gaps = 1'b1;
      clr(); fre[100] = -25'sd7; fim[100] = 25'sd24;
      send(1024, 1'b1); expect_peak(100, 50'd625);
      clr(); fre[200] = 25'sd1000; fim[200] = 25'sd1000;
      for (int i = 0; i < 400; i++) beat(i == 0, 1'b0, i);
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst2_peak_valid", 64'(peak_valid), 64'd0);
      chk("rst2_peak_bin", 64'(peak_bin), 64'd0);
      chk("rst2_peak_mag", 64'(peak_mag), 64'd0);
      chk("rst2_frame_err", 64'(frame_err), 64'd0);
      reset = 1'b0;
      for (int i = 400; i < 1024; i++) beat(1'b0, i == 1023, i);
      gaps = 1'b0;
      repeat (10) idle();
      @(negedge clk);
      chk("peak_q_drained", 64'(peak_q.size()), 64'd0);
      chk("err_q_drained", 64'(err_q.size()), 64'd0);
      chk("post_rst_bin", 64'(peak_bin), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
